// File: rtl/psg_write_queue.sv
// psg_write_queue: buffers CPU byte writes and replays them onto the PSG pins,
// one sampled write per byte, paced by clk_en with a settle gap between writes.
module psg_write_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int GAP   = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clk_en,
    input  logic          cpu_wr,
    input  logic [7:0]    cpu_data,
    output logic          cpu_busy,
    output logic [AW:0]   fifo_count,
    output logic          overflow,
    input  logic          ovf_clr,
    output logic [7:0]    psg_d,
    output logic          psg_ce_n,
    output logic          psg_we_n,
    input  logic          psg_ready
);
    localparam int GW = (GAP < 1) ? 1 : $clog2(GAP + 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_GAP} state_t;

    state_t         state_q, state_d;
    logic [7:0]     mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic [7:0]     psg_d_q, psg_d_d;
    logic           overflow_q, overflow_d;
    logic           full, push, pop;

    always_comb begin
        full       = count_q == (AW+1)'(DEPTH);
        push       = cpu_wr && !full;
        pop        = state_q == S_IDLE && count_q != '0;
        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
        overflow_d = (cpu_wr && full) ? 1'b1 : ovf_clr ? 1'b0 : overflow_q;
        psg_d_d    = pop ? mem_q[rd_ptr_q] : psg_d_q;
        state_d    = state_q;
        gap_d      = gap_q;
        case (state_q)
            S_IDLE:   state_d = pop ? S_SETUP : S_IDLE;
            S_SETUP:  state_d = clk_en ? S_STROBE : S_SETUP;
            S_STROBE: begin
                if (clk_en && psg_ready) begin
                    state_d = S_GAP;
                    gap_d   = GW'(GAP);
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                end else if (clk_en) begin
                    gap_d   = gap_q - GW'(1);
                    state_d = (gap_q == GW'(1)) ? S_IDLE : S_GAP;
                end
            end
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            gap_q      <= '0;
            psg_d_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            gap_q      <= gap_d;
            psg_d_q    <= psg_d_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= cpu_data;
    end

    assign cpu_busy   = full;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign psg_d      = psg_d_q;
    assign psg_ce_n   = state_q != S_STROBE;
    assign psg_we_n   = state_q != S_STROBE;
endmodule

// File: tb/tb_psg_write_queue.sv
// tb_psg_write_queue: directed stimulus with a scoreboard of expected PSG writes,
// checked by an independent pin monitor.
module tb_psg_write_queue;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int GAP   = 2;

    logic          clk = 0;
    logic          reset = 1;
    logic          clk_en = 0;
    logic          cpu_wr = 0;
    logic [7:0]    cpu_data = 0;
    logic          cpu_busy;
    logic [AW:0]   fifo_count;
    logic          overflow;
    logic          ovf_clr = 0;
    logic [7:0]    psg_d;
    logic          psg_ce_n;
    logic          psg_we_n;
    logic          psg_ready = 1;

    psg_write_queue #(.DEPTH(DEPTH), .AW(AW), .GAP(GAP)) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .cpu_wr(cpu_wr),
        .cpu_data(cpu_data), .cpu_busy(cpu_busy), .fifo_count(fifo_count),
        .overflow(overflow), .ovf_clr(ovf_clr), .psg_d(psg_d),
        .psg_ce_n(psg_ce_n), .psg_we_n(psg_we_n), .psg_ready(psg_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [7:0] sb [$];
    int mode = 0;
    int en_cnt = 0, wr_cnt = 0, last_en = 0, gap_en = 0, min_gap = 999;
    bit in_strobe = 0, have_prev = 0, prev_rst = 1;
    logic [7:0] strobe_d = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // clk_en source: 0 = always low, 1 = always high, 2 = one pulse every 16 clocks
    initial begin
        int div = 0;
        forever begin
            @(posedge clk);
            #1;
            clk_en = (mode == 1) || (mode == 2 && div == 15);
            div = (div + 1) % 16;
        end
    end

    // Pin monitor: a write is sampled by the PSG at a rising edge with strobes low, clk_en and ready high.
    initial begin
        forever begin
            @(negedge clk);
            if (!psg_ce_n && !psg_we_n && !in_strobe) begin
                in_strobe = 1;
                en_cnt = 0;
                wr_cnt = 0;
                strobe_d = psg_d;
                if (have_prev && gap_en < min_gap) min_gap = gap_en;
            end else if (psg_ce_n && in_strobe) begin
                in_strobe = 0;
                if (!prev_rst) chk("writes_per_strobe", wr_cnt, 1);
                last_en = en_cnt;
                have_prev = 1;
                gap_en = 0;
            end
            if (psg_ce_n != psg_we_n) chk("ce_we_equal", int'(psg_ce_n), int'(psg_we_n));
            if (in_strobe) begin
                if (clk_en) en_cnt++;
                if (psg_d != strobe_d) chk("psg_d_stable", psg_d, strobe_d);
                if (clk_en && psg_ready) begin
                    wr_cnt++;
                    if (sb.size() == 0) chk("unexpected_write", psg_d, -1);
                    else chk("psg_write_data", psg_d, sb.pop_front());
                end
            end else if (clk_en) begin
                gap_en++;
            end
            prev_rst = reset;
        end
    end

    task automatic wr(input logic [7:0] b);
        cpu_wr = 1;
        cpu_data = b;
        @(posedge clk);
        #1;
        cpu_wr = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_mode(input int m);
        mode = m;
        tick(2);
    endtask

    task automatic wait_drain(input string name, input int n);
        bit done = 0;
        for (int i = 0; i < n; i++) begin
            if (sb.size() == 0 && fifo_count == 0 && psg_ce_n) begin
                done = 1;
                break;
            end
            tick(1);
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s_timeout: queue=%0d count=%0d expected both 0", name, sb.size(), fifo_count);
        end
        tick(48);
    endtask

    task automatic wait_strobe(input string name);
        bit seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!psg_ce_n) begin
                seen = 1;
                break;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s_timeout: strobe never went low", name);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        reset = 0;
        chk("rst_count", fifo_count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_busy", cpu_busy, 0);
        chk("rst_psg_d", psg_d, 0);
        chk("rst_ce_n", psg_ce_n, 1);
        chk("rst_we_n", psg_we_n, 1);

        // single write with sparse clk_en
        set_mode(2);
        sb.push_back(8'h9F);
        wr(8'h9F);
        wait_drain("t1", 300);
        chk("t1_en_in_strobe", last_en, 1);
        chk("t1_psg_d", psg_d, 8'h9F);
        chk("t1_count", fifo_count, 0);
        chk("t1_overflow", overflow, 0);

        // back-to-back burst with clk_en constant
        set_mode(1);
        have_prev = 0;
        min_gap = 999;
        foreach (sb[i]) sb.delete(i);
        sb.push_back(8'h8A); sb.push_back(8'h3F); sb.push_back(8'h90);
        wr(8'h8A); wr(8'h3F); wr(8'h90);
        wait_drain("t2", 100);
        total++;
        if (min_gap < GAP + 1) begin
            bad++;
            $display("FAIL t2_min_gap: got %0d clk_en between strobes, expected at least %0d", min_gap, GAP + 1);
        end

        // fill with clk_en low: head sits in SETUP, 8 more fit, the 10th is dropped
        set_mode(0);
        for (int i = 1; i <= 10; i++) begin
            if (i <= 9) sb.push_back(8'(i));
            wr(8'(i));
            if (i == 8) chk("t3_busy_after8", cpu_busy, 0);
            if (i == 9) begin
                chk("t3_count_full", fifo_count, DEPTH);
                chk("t3_busy_full", cpu_busy, 1);
                chk("t3_ovf_before_drop", overflow, 0);
            end
        end
        chk("t3_ovf_set", overflow, 1);
        chk("t3_count_after_drop", fifo_count, DEPTH);
        ovf_clr = 1;
        wr(8'hAA);
        ovf_clr = 0;
        chk("t3_set_beats_clr", overflow, 1);
        ovf_clr = 1;
        tick(1);
        ovf_clr = 0;
        chk("t3_ovf_cleared", overflow, 0);
        set_mode(1);
        wait_drain("t3", 200);

        // ready held low inside STROBE for 5 clk_en pulses
        psg_ready = 0;
        sb.push_back(8'h55);
        wr(8'h55);
        wait_strobe("t4");
        repeat (5) @(posedge clk);
        #1;
        chk("t4_still_strobing", psg_ce_n, 0);
        psg_ready = 1;
        wait_drain("t4", 100);
        chk("t4_en_in_strobe", last_en, 6);

        // reset while in STROBE with 4 bytes queued
        psg_ready = 0;
        wr(8'hC1); wr(8'hC2); wr(8'hC3); wr(8'hC4); wr(8'hC5);
        chk("t5_count_before", fifo_count, 4);
        chk("t5_strobe_low", psg_ce_n, 0);
        reset = 1;
        tick(1);
        chk("t5_ce_n", psg_ce_n, 1);
        chk("t5_we_n", psg_we_n, 1);
        chk("t5_count", fifo_count, 0);
        reset = 0;
        psg_ready = 1;
        tick(40);
        chk("t5_count_later", fifo_count, 0);
        chk("t5_ce_n_later", psg_ce_n, 1);

        // push in the same cycle IDLE pops the last entry
        set_mode(0);
        sb.push_back(8'h11); sb.push_back(8'hE4);
        wr(8'h11);
        wr(8'hE4);
        chk("t6_count", fifo_count, 1);
        chk("t6_psg_d", psg_d, 8'h11);
        set_mode(1);
        wait_drain("t6", 100);
        chk("t6_last_psg_d", psg_d, 8'hE4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
